// File: rtl/key_sw_pkg.sv
// Shared register map and sizing helper for the key/switch Avalon-MM slave.
package key_sw_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_EDGE  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    // The debounce counter only has to reach cycles-1; never narrower than one bit.
    function automatic int unsigned dbnc_cnt_w(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit 2-FF synchronizer plus debounce counter and stable register.
// RST_LEVEL is the synchronizer reset level; INVERT flips the synced polarity.
module debounce_bit
    import key_sw_pkg::*;
#(
    parameter int unsigned CYCLES    = 4,
    parameter int unsigned CNT_W     = dbnc_cnt_w(CYCLES),
    parameter logic        RST_LEVEL = 1'b0,
    parameter logic        INVERT    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o,
    output logic accept_o
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CYCLES - 1);

    logic [1:0]       sync_q;
    logic             synced;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign synced = sync_q[1] ^ INVERT;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CntMax) begin
                accept   = 1'b1;
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= {2{RST_LEVEL}};
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign accept_o = accept;

endmodule

// File: rtl/key_sw_avalon_slave.sv
// Debounced switches/keys as a 4-word Avalon-MM slave with edge capture, press counter and IRQ.
// Define KEYSW_SW_EDGE_EN to also capture and unmask switch changes in EDGE/MASK.
module key_sw_avalon_slave
    import key_sw_pkg::*;
#(
    parameter int unsigned SW_W            = 8,
    parameter int unsigned KEY_W           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [SW_W-1:0]   SW,
    input  logic [KEY_W-1:0]  KEY,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [1:0]        AVL_ADDR,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    output logic              IRQ
);

    localparam int unsigned InW = SW_W + KEY_W;
`ifdef KEYSW_SW_EDGE_EN
    localparam int unsigned EdgeW = InW;
`else
    localparam int unsigned EdgeW = KEY_W;
`endif
    localparam int unsigned DbW = dbnc_cnt_w(DEBOUNCE_CYCLES);

    logic [InW-1:0]   raw, stable, accept;
    logic [KEY_W-1:0] key_rise;
    logic [EdgeW-1:0] edge_set;
    logic             press0;

    assign raw = {KEY, SW};

    for (genvar i = 0; i < int'(InW); i++) begin : g_dbnc
        debounce_bit #(
            .CYCLES    (DEBOUNCE_CYCLES),
            .CNT_W     (DbW),
            .RST_LEVEL (i >= int'(SW_W)),
            .INVERT    (i >= int'(SW_W))
        ) u_dbnc (
            .clk_i    (CLK),
            .rst_i    (RESET),
            .raw_i    (raw[i]),
            .stable_o (stable[i]),
            .accept_o (accept[i])
        );
    end

    // accept fires on the cycle stable flips, so accept & ~stable is a 0->1 edge.
    assign key_rise = accept[InW-1:SW_W] & ~stable[InW-1:SW_W];
    assign press0   = key_rise[0];

`ifdef KEYSW_SW_EDGE_EN
    assign edge_set = {accept[SW_W-1:0], key_rise};
`else
    logic unused_sw_accept;
    assign edge_set         = key_rise;
    assign unused_sw_accept = ^accept[SW_W-1:0];
`endif

    logic             wr, rd;
    logic [31:0]      be32, wsel;
    logic             unused_bus;
    logic [EdgeW-1:0] edge_q, edge_d;
    logic [EdgeW-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      rdata_q, rdata_d, rmux;
    logic             irq_q, irq_d;

    assign wr         = AVL_CS & AVL_WRITE;
    assign rd         = AVL_CS & AVL_READ;
    assign be32       = {{8{AVL_BYTE_EN[3]}}, {8{AVL_BYTE_EN[2]}},
                         {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};
    assign wsel       = AVL_WRITEDATA & be32;
    assign unused_bus = ^{wsel, be32};

    always_comb begin
        edge_d  = edge_q;
        mask_d  = mask_q;
        count_d = count_q + {{(CNT_W-1){1'b0}}, press0};
        if (wr) begin
            unique case (AVL_ADDR)
                ADDR_DATA:  ;
                ADDR_EDGE:  edge_d  = edge_q & ~wsel[EdgeW-1:0];
                ADDR_MASK:  mask_d  = (mask_q & ~be32[EdgeW-1:0]) | wsel[EdgeW-1:0];
                ADDR_COUNT: count_d = {{(CNT_W-1){1'b0}}, press0};
            endcase
        end
        // New edges are applied after the W1C clear so a coincident set wins.
        edge_d = edge_d | edge_set;
    end

    always_comb begin
        rmux = '0;
        unique case (AVL_ADDR)
            ADDR_DATA:  rmux[InW-1:0]   = stable;
            ADDR_EDGE:  rmux[EdgeW-1:0] = edge_q;
            ADDR_MASK:  rmux[EdgeW-1:0] = mask_q;
            ADDR_COUNT: rmux[CNT_W-1:0] = count_q;
        endcase
        rdata_d = rd ? rmux : rdata_q;
        irq_d   = |(edge_q & mask_q);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            edge_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign AVL_READDATA = rdata_q;
    assign IRQ          = irq_q;

endmodule

// File: tb/tb_key_sw_avalon_slave.sv
// Directed bench for key_sw_avalon_slave with DEBOUNCE_CYCLES=4; a second instance with a
// 2-bit counter covers counter wrap.
module tb_key_sw_avalon_slave;
    import key_sw_pkg::*;

`ifdef KEYSW_SW_EDGE_EN
    localparam bit SwEdge = 1'b1;
`else
    localparam bit SwEdge = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic [1:0]  key;
    logic        cs, rd, wr;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata_m, rdata_w;
    logic        irq_m, irq_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    key_sw_avalon_slave #(
        .SW_W(8), .KEY_W(2), .DEBOUNCE_CYCLES(4), .CNT_W(16)
    ) dut (
        .CLK(clk), .RESET(rst), .SW(sw), .KEY(key),
        .AVL_CS(cs), .AVL_READ(rd), .AVL_WRITE(wr), .AVL_ADDR(addr),
        .AVL_BYTE_EN(be), .AVL_WRITEDATA(wdata),
        .AVL_READDATA(rdata_m), .IRQ(irq_m)
    );

    key_sw_avalon_slave #(
        .SW_W(8), .KEY_W(2), .DEBOUNCE_CYCLES(4), .CNT_W(2)
    ) dut_wrap (
        .CLK(clk), .RESET(rst), .SW(sw), .KEY(key),
        .AVL_CS(cs), .AVL_READ(rd), .AVL_WRITE(wr), .AVL_ADDR(addr),
        .AVL_BYTE_EN(be), .AVL_WRITEDATA(wdata),
        .AVL_READDATA(rdata_w), .IRQ(irq_w)
    );

    typedef struct {
        string       name;
        logic [7:0]  sw;
        logic [1:0]  key;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the following posedge performs the write.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; wdata = '0; be = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] dm, output logic [31:0] dw);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        dm = rdata_m;
        dw = rdata_w;
    endtask

    task automatic press_k0();
        key[0] = 1'b0;
        tick(8);
        key[0] = 1'b1;
        tick(8);
    endtask

    initial begin
        logic [31:0] dm, dw;
        logic        irq_seen;

        vecs[0] = '{"data_a5_idle", 8'hA5, 2'b11, 32'h0000_00A5};
        vecs[1] = '{"data_3c_key0", 8'h3C, 2'b10, 32'h0000_013C};
        vecs[2] = '{"data_ff_both", 8'hFF, 2'b00, 32'h0000_03FF};
        vecs[3] = '{"data_00_key1", 8'h00, 2'b01, 32'h0000_0200};
        vecs[4] = '{"data_5a_idle", 8'h5A, 2'b11, 32'h0000_005A};

        rst = 1'b1; sw = 8'hA5; key = 2'b11;
        cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
        tick(3);
        check("reset_rdata", rdata_m, 32'h0);
        check("reset_irq", 32'(irq_m), 32'h0);
        rst = 1'b0;
        tick(10);
        bus_read(ADDR_DATA, dm, dw);
        check("reset_data", dm, 32'h0000_00A5);
        bus_read(ADDR_EDGE, dm, dw);
        check("reset_edge", dm, SwEdge ? 32'h0000_0294 : 32'h0);
        bus_read(ADDR_MASK, dm, dw);
        check("reset_mask", dm, 32'h0);
        bus_read(ADDR_COUNT, dm, dw);
        check("reset_count", dm, 32'h0);
        check("reset_irq_after", 32'(irq_m), 32'h0);

        foreach (vecs[i]) begin
            sw  = vecs[i].sw;
            key = vecs[i].key;
            tick(10);
            bus_read(ADDR_DATA, dm, dw);
            check(vecs[i].name, dm, vecs[i].exp);
            check({vecs[i].name, "_wrap_inst"}, dw, vecs[i].exp);
        end
        sw = 8'hA5; key = 2'b11;
        tick(10);
        bus_read(ADDR_COUNT, dm, dw);
        check("table_count", dm, 32'h1);
        bus_write(ADDR_EDGE, 32'hFFFF_FFFF, 4'hF);
        bus_write(ADDR_COUNT, 32'h0, 4'hF);
        bus_write(ADDR_DATA, 32'hFFFF_FFFF, 4'hF);
        bus_read(ADDR_EDGE, dm, dw);
        check("edge_cleared", dm, 32'h0);
        bus_read(ADDR_COUNT, dm, dw);
        check("count_cleared", dm, 32'h0);
        bus_read(ADDR_DATA, dm, dw);
        check("data_write_ignored", dm, 32'h0000_00A5);

        // Glitch of 3 cycles must be rejected.
        key[0] = 1'b0;
        tick(3);
        key[0] = 1'b1;
        tick(10);
        bus_read(ADDR_DATA, dm, dw);
        check("glitch_data", dm, 32'h0000_00A5);
        bus_read(ADDR_COUNT, dm, dw);
        check("glitch_count", dm, 32'h0);

        // Clean press: stable flips at the 6th posedge, visible on readdata one cycle later.
        cs = 1'b1; rd = 1'b1; addr = ADDR_DATA;
        key[0] = 1'b0;
        tick(6);
        check("hold_not_yet", 32'(rdata_m[8]), 32'h0);
        tick(1);
        check("hold_accepted", 32'(rdata_m[8]), 32'h1);
        cs = 1'b0; rd = 1'b0;
        tick(1);
        key[0] = 1'b1;
        tick(10);
        bus_read(ADDR_EDGE, dm, dw);
        check("hold_edge", dm, 32'h1);
        bus_read(ADDR_COUNT, dm, dw);
        check("hold_count", dm, 32'h1);

        // Interrupt path.
        bus_write(ADDR_EDGE, 32'h1, 4'hF);
        bus_write(ADDR_MASK, 32'h1, 4'h1);
        bus_write(ADDR_MASK, 32'hFFFF_FFFF, 4'hC);
        bus_read(ADDR_MASK, dm, dw);
        check("mask_byte_en", dm, 32'h1);
        check("irq_idle", 32'(irq_m), 32'h0);
        key[0] = 1'b0;
        tick(6);
        check("irq_before_edge", 32'(irq_m), 32'h0);
        tick(1);
        check("irq_rise", 32'(irq_m), 32'h1);
        check("irq_rise_wrap_inst", 32'(irq_w), 32'h1);
        tick(1);
        key[0] = 1'b1;
        tick(8);
        bus_write(ADDR_EDGE, 32'h1, 4'hF);
        check("irq_lag", 32'(irq_m), 32'h1);
        tick(1);
        check("irq_fall", 32'(irq_m), 32'h0);

        irq_seen = 1'b0;
        key[1] = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c == 8) key[1] = 1'b1;
            @(negedge clk);
            irq_seen = irq_seen | irq_m;
        end
        bus_read(ADDR_EDGE, dm, dw);
        check("key1_edge", dm, 32'h2);
        check("key1_irq_masked", 32'(irq_seen), 32'h0);
        bus_read(ADDR_COUNT, dm, dw);
        check("key1_no_count", dm, 32'h2);

        // W1C on the same cycle as a new set: set wins.
        bus_write(ADDR_EDGE, 32'h3, 4'hF);
        key[0] = 1'b0;
        tick(5);
        bus_write(ADDR_EDGE, 32'h1, 4'hF);
        tick(2);
        key[0] = 1'b1;
        tick(8);
        bus_read(ADDR_EDGE, dm, dw);
        check("race_set_wins", dm, 32'h1);
        check("race_irq", 32'(irq_m), 32'h1);

        // Counter: wrap on the 2-bit instance and clear/press coincidence.
        bus_write(ADDR_COUNT, 32'h0, 4'hF);
        for (int p = 0; p < 3; p++) press_k0();
        bus_read(ADDR_COUNT, dm, dw);
        check("count_three", dm, 32'h3);
        check("count_three_wrap_inst", dw, 32'h3);
        press_k0();
        bus_read(ADDR_COUNT, dm, dw);
        check("count_four", dm, 32'h4);
        check("count_wrap", dw, 32'h0);
        key[0] = 1'b0;
        tick(5);
        bus_write(ADDR_COUNT, 32'h0, 4'h0);
        tick(2);
        key[0] = 1'b1;
        tick(8);
        bus_read(ADDR_COUNT, dm, dw);
        check("count_clear_press", dm, 32'h1);
        check("count_clear_press_wrap_inst", dw, 32'h1);

        // Switch edge capture (present only in the KEYSW_SW_EDGE_EN build).
        bus_write(ADDR_EDGE, 32'hFFFF_FFFF, 4'hF);
        bus_write(ADDR_MASK, 32'h0, 4'hF);
        sw[3] = 1'b1;
        tick(8);
        sw[3] = 1'b0;
        tick(10);
        bus_read(ADDR_EDGE, dm, dw);
        check("sw_edge", dm, SwEdge ? 32'h20 : 32'h0);
        check("sw_edge_unmasked_irq", 32'(irq_m), 32'h0);
        bus_write(ADDR_EDGE, 32'h20, 4'hF);
        bus_read(ADDR_EDGE, dm, dw);
        check("sw_edge_w1c", dm, 32'h0);
        bus_write(ADDR_MASK, 32'h20, 4'hF);
        bus_read(ADDR_MASK, dm, dw);
        check("sw_mask", dm, SwEdge ? 32'h20 : 32'h0);
        sw[3] = 1'b1;
        tick(8);
        sw[3] = 1'b0;
        tick(10);
        check("sw_irq", 32'(irq_m), SwEdge ? 32'h1 : 32'h0);
        bus_write(ADDR_EDGE, 32'hFFFF_FFFF, 4'hF);
        tick(2);
        check("final_irq_clear", 32'(irq_m), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
